muldiv_ctrl: RTL and testbench
==============================

Name: muldiv_ctrl

Overview:
EX-stage sequencer for the multi-cycle HI/LO operations: MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Owns the architectural HI and LO registers and feeds them to the ALU's hi/lo inputs.
- Drives the ALU's ex_valid_ns, and drives ex_allin back to ID.
- Holds the instruction in EX while an iterative multiply or divide runs.
- Passes all other ops through with zero added latency.

Parameters:
MUL_LAT, 2, cycles spent in MUL state before the result is valid (1..8)
DIV_ITER, 32, restoring-divider iterations; fixed to the word width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
flush  in  1  pipeline flush (exception/mispredict); synchronous abort
ex_valid_in  in  1  ID holds a valid instruction for EX
op  in  AluOpBus(6)  decoded op, held stable by ID while ex_allin=0
scr0_data  in  32  rs operand / dividend / multiplicand
scr1_data  in  32  rt operand / divisor / multiplier
wb_allin  in  1  WB can accept
ex_valid_ns  out  1  to ALU: EX result ready to pass to WB
ex_allin  out  1  to ID: EX consumes the current instruction this cycle
hi  out  32  architectural HI
lo  out  32  architectural LO
busy  out  1  state is not IDLE

Behaviour:
- Interface decisions:
  - One clock, clk.
  - reset is asynchronous and active-high.
  - Reset values: state=IDLE, hi=0, lo=0, counter=0, all datapath registers=0.
  - Reset values of combinational outputs: ex_valid_ns=0, ex_allin=0, busy=0.
- is_md = op in {`INSN_MULT, `INSN_MULTU, `INSN_DIV, `INSN_DIVU}.
- States: IDLE, MUL, DIV, DONE.
- IDLE with !is_md (pass-through):
  - ex_valid_ns = ex_valid_in; ex_allin = wb_allin.
  - `INSN_MTHI / `INSN_MTLO: hi (or lo) <= scr0_data on the edge where ex_valid_in && wb_allin && !flush.
- IDLE with ex_valid_in && is_md && !flush:
  - ex_valid_ns=0, ex_allin=0.
  - Latch operand magnitudes (signed ops: abs value) plus result-sign and remainder-sign bits.
  - MULT/MULTU: go to MUL, counter = MUL_LAT-1.
  - DIV/DIVU with scr1_data==0: go straight to DONE with LO result=32'hFFFFFFFF and HI result=scr0_data. No sign fix.
  - DIV/DIVU otherwise: go to DIV, counter = DIV_ITER-1, partial remainder=0.
- MUL:
  - Registered 64-bit unsigned product of the magnitudes; negate if the result-sign bit is set.
  - Decrement the counter; at 0 go to DONE.
- DIV:
  - One restoring step per cycle: shift {rem, quo} left by 1, trial-subtract the divisor, set the quotient bit if the result is non-negative.
  - At counter 0 go to DONE.
  - Sign fix on exit: quotient negated if the operand signs differ; remainder takes the dividend's sign.
- DONE:
  - ex_valid_ns=1, ex_allin=wb_allin.
  - On wb_allin: hi<=result_hi, lo<=result_lo, go to IDLE.
  - If wb_allin=0: stay in DONE with HI/LO unchanged.
- Latency from cycle 0 (cycle 0 = IDLE with the op presented):
  - MUL*: DONE at cycle MUL_LAT+1.
  - DIV*: DONE at cycle 33.
  - Divide by zero: DONE at cycle 1.
- ex_valid_ns and ex_allin are combinational from state, op, ex_valid_in and wb_allin.
- flush (any state): go to IDLE next edge, no HI/LO write; ex_valid_ns=0 and ex_allin=1 during the flush cycle.
- flush has priority over a DONE commit and over an MTHI/MTLO write.
- reset mid-operation: immediate return to reset values.
- An MFHI/MFLO following a mul/div cannot enter EX before the commit edge, so no HI/LO forwarding is required.
- The ALU reads hi/lo the cycle after commit.

Decomposition:
- Shared package / cpu.h: MD_IDLE, MD_MUL, MD_DIV, MD_DONE state encodings; MUL_LAT default; DIV_ITER.
- Op codes come from isa.h (`INSN_MULT etc.).
- One sub-module is natural: muldiv_div_step.
  - Combinational single restoring iteration.
  - Inputs: rem[31:0], quo[31:0], divisor.
  - Outputs: next rem, next quo.
  - The FSM instantiates it once and iterates.

Test Plan:
- MULT scr0=32'hFFFFFFFD (-3), scr1=5, wb_allin=1 -> ex_valid_ns rises at cycle 3; after commit hi=32'hFFFFFFFF, lo=32'hFFFFFFF1; ex_allin=0 for cycles 0-2.
- DIVU scr0=100, scr1=7 -> DONE at cycle 33; lo=14, hi=2. DIV scr0=-7, scr1=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
- DIV scr1=0, scr0=32'h1234 -> DONE at cycle 1; lo=32'hFFFFFFFF, hi=32'h1234.
- DIVU in flight, flush at cycle 10 -> IDLE next cycle; hi/lo keep their prior values; a following ADD passes through with ex_valid_ns=ex_valid_in.
- MULTU 32'hFFFFFFFF*32'hFFFFFFFF with wb_allin=0 for 4 cycles in DONE -> ex_valid_ns held at 1, ex_allin=0, hi/lo unchanged; on wb_allin=1 commit hi=32'hFFFFFFFE, lo=1.
- MTHI scr0=32'hA5A5A5A5 with wb_allin=0 then 1 -> hi updates only on the wb_allin=1 edge. Assert reset mid-DIV -> busy=0 and hi=lo=0 immediately (asynchronous).

Source files
------------

// File: rtl/muldiv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_ctrl_pkg
// Description : Shared state encodings, latency defaults, op codes and helpers
//               for the HI/LO multiply/divide sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_ctrl_pkg;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2,
        MD_DONE = 2'd3
    } md_state_t;

    localparam int MD_MUL_LAT  = 2;
    localparam int MD_DIV_ITER = 32;

    localparam logic [5:0] INSN_ADD   = 6'h20;
    localparam logic [5:0] INSN_MTHI  = 6'h11;
    localparam logic [5:0] INSN_MTLO  = 6'h13;
    localparam logic [5:0] INSN_MULT  = 6'h18;
    localparam logic [5:0] INSN_MULTU = 6'h19;
    localparam logic [5:0] INSN_DIV   = 6'h1A;
    localparam logic [5:0] INSN_DIVU  = 6'h1B;

    // Two's-complement magnitude; 32'h80000000 maps to itself, which is the
    // correct unsigned magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage : muldiv_ctrl_pkg
`default_nettype wire

// File: rtl/muldiv_div_step.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_div_step
// Description : One combinational restoring-division iteration.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_div_step (
    input  logic [31:0] i_rem,
    input  logic [31:0] i_quo,
    input  logic [31:0] i_divisor,
    output logic [31:0] o_rem,
    output logic [31:0] o_quo
);

    logic [32:0] w_shifted;
    logic [32:0] w_trial;

    // Partial remainder is always below the divisor, so 33 bits hold the shift.
    assign w_shifted = {i_rem, i_quo[31]};
    assign w_trial   = w_shifted - {1'b0, i_divisor};

    always_comb begin
        if (!w_trial[32]) begin
            o_rem = w_trial[31:0];
            o_quo = {i_quo[30:0], 1'b1};
        end else begin
            o_rem = w_shifted[31:0];
            o_quo = {i_quo[30:0], 1'b0};
        end
    end

endmodule : muldiv_div_step
`default_nettype wire

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_ctrl
// Description : EX-stage sequencer for MULT/MULTU/DIV/DIVU/MTHI/MTLO; owns the
//               architectural HI/LO registers and stalls EX while iterating.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int MUL_LAT  = MD_MUL_LAT,
    parameter int DIV_ITER = MD_DIV_ITER
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        ex_valid_in,
    input  logic [5:0]  op,
    input  logic [31:0] scr0_data,
    input  logic [31:0] scr1_data,
    input  logic        wb_allin,
    output logic        ex_valid_ns,
    output logic        ex_allin,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy
);

    md_state_t   r_state;
    md_state_t   w_state_nx;
    logic [5:0]  r_cnt;
    logic [31:0] r_a_mag;
    logic [31:0] r_b_mag;
    logic        r_res_neg;
    logic        r_rem_neg;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_res_hi;
    logic [31:0] r_res_lo;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_is_mul;
    logic        w_is_div;
    logic        w_is_md;
    logic        w_is_signed;
    logic [63:0] w_prod;
    logic [63:0] w_prod_fix;
    logic [31:0] w_rem_nx;
    logic [31:0] w_quo_nx;
    logic [31:0] w_rem_fix;
    logic [31:0] w_quo_fix;

    assign w_is_mul    = (op == INSN_MULT) || (op == INSN_MULTU);
    assign w_is_div    = (op == INSN_DIV)  || (op == INSN_DIVU);
    assign w_is_md     = w_is_mul || w_is_div;
    assign w_is_signed = (op == INSN_MULT) || (op == INSN_DIV);

    assign w_prod     = {32'd0, r_a_mag} * {32'd0, r_b_mag};
    assign w_prod_fix = r_res_neg ? (~w_prod + 64'd1) : w_prod;

    muldiv_div_step u_div_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_b_mag),
        .o_rem     (w_rem_nx),
        .o_quo     (w_quo_nx)
    );

    assign w_quo_fix = r_res_neg ? (~w_quo_nx + 32'd1) : w_quo_nx;
    assign w_rem_fix = r_rem_neg ? (~w_rem_nx + 32'd1) : w_rem_nx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= MD_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        ex_valid_ns = 1'b0;
        ex_allin    = 1'b0;
        case (r_state)
            MD_IDLE: begin
                if (ex_valid_in && w_is_md) begin
                    if (!w_is_div)
                        w_state_nx = MD_MUL;
                    else if (scr1_data == 32'd0)
                        w_state_nx = MD_DONE;
                    else
                        w_state_nx = MD_DIV;
                end else begin
                    ex_valid_ns = ex_valid_in;
                    ex_allin    = wb_allin;
                end
            end
            MD_MUL, MD_DIV: begin
                if (r_cnt == 6'd0)
                    w_state_nx = MD_DONE;
            end
            MD_DONE: begin
                ex_valid_ns = 1'b1;
                ex_allin    = wb_allin;
                if (wb_allin)
                    w_state_nx = MD_IDLE;
            end
            default: w_state_nx = MD_IDLE;
        endcase
        // Abort wins over everything, including a pending commit.
        if (flush) begin
            w_state_nx  = MD_IDLE;
            ex_valid_ns = 1'b0;
            ex_allin    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= 6'd0;
            r_a_mag   <= 32'd0;
            r_b_mag   <= 32'd0;
            r_res_neg <= 1'b0;
            r_rem_neg <= 1'b0;
            r_rem     <= 32'd0;
            r_quo     <= 32'd0;
            r_res_hi  <= 32'd0;
            r_res_lo  <= 32'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
        end else if (!flush) begin
            case (r_state)
                MD_IDLE: begin
                    if (ex_valid_in && w_is_md) begin
                        r_a_mag   <= w_is_signed ? abs32(scr0_data) : scr0_data;
                        r_b_mag   <= w_is_signed ? abs32(scr1_data) : scr1_data;
                        r_res_neg <= w_is_signed && (scr0_data[31] ^ scr1_data[31]);
                        r_rem_neg <= w_is_signed && scr0_data[31];
                        if (w_is_mul) begin
                            r_cnt <= 6'(MUL_LAT - 1);
                        end else if (scr1_data == 32'd0) begin
                            r_res_lo <= 32'hFFFF_FFFF;
                            r_res_hi <= scr0_data;
                        end else begin
                            r_cnt <= 6'(DIV_ITER - 1);
                            r_rem <= 32'd0;
                            r_quo <= w_is_signed ? abs32(scr0_data) : scr0_data;
                        end
                    end else if (ex_valid_in && wb_allin) begin
                        if (op == INSN_MTHI) r_hi <= scr0_data;
                        if (op == INSN_MTLO) r_lo <= scr0_data;
                    end
                end
                MD_MUL: begin
                    {r_res_hi, r_res_lo} <= w_prod_fix;
                    if (r_cnt != 6'd0) r_cnt <= r_cnt - 6'd1;
                end
                MD_DIV: begin
                    r_rem <= w_rem_nx;
                    r_quo <= w_quo_nx;
                    if (r_cnt != 6'd0) begin
                        r_cnt <= r_cnt - 6'd1;
                    end else begin
                        r_res_lo <= w_quo_fix;
                        r_res_hi <= w_rem_fix;
                    end
                end
                MD_DONE: begin
                    if (wb_allin) begin
                        r_hi <= r_res_hi;
                        r_lo <= r_res_lo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign busy = (r_state != MD_IDLE);

endmodule : muldiv_ctrl
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_ctrl
// Description : Directed self-checking bench for the HI/LO mul/div sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        ex_valid_in;
    logic [5:0]  op;
    logic [31:0] scr0_data;
    logic [31:0] scr1_data;
    logic        wb_allin;
    logic        ex_valid_ns;
    logic        ex_allin;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    muldiv_ctrl u_dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .ex_valid_in (ex_valid_in),
        .op          (op),
        .scr0_data   (scr0_data),
        .scr1_data   (scr1_data),
        .wb_allin    (wb_allin),
        .ex_valid_ns (ex_valid_ns),
        .ex_allin    (ex_allin),
        .hi          (hi),
        .lo          (lo),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a mul/div op and counts cycles until ex_valid_ns rises.
    task automatic issue(input string tag, input logic [5:0] o,
                         input logic [31:0] a, input logic [31:0] b, input int exp_cyc);
        int cyc;
        op = o; scr0_data = a; scr1_data = b; ex_valid_in = 1'b1;
        #1;
        cyc = 0;
        while (ex_valid_ns !== 1'b1 && cyc < 60) begin
            tick();
            cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'(exp_cyc));
    endtask

    task automatic commit();
        wb_allin = 1'b1;
        tick();
        ex_valid_in = 1'b0;
        op = INSN_ADD;
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; ex_valid_in = 1'b0; op = INSN_ADD;
        scr0_data = 32'd0; scr1_data = 32'd0; wb_allin = 1'b0;
        tick(); tick();
        check("rst_busy",  64'(busy), 64'd0);
        check("rst_hi",    64'(hi), 64'd0);
        check("rst_lo",    64'(lo), 64'd0);
        check("rst_valid", 64'(ex_valid_ns), 64'd0);
        check("rst_allin", 64'(ex_allin), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // MULT -3 * 5: stall for cycles 0..2, valid at cycle 3
        wb_allin = 1'b1;
        op = INSN_MULT; scr0_data = 32'hFFFF_FFFD; scr1_data = 32'd5; ex_valid_in = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("mult_allin_c%0d", c), 64'(ex_allin), 64'd0);
            check($sformatf("mult_valid_c%0d", c), 64'(ex_valid_ns), 64'd0);
            tick();
        end
        check("mult_valid_c3", 64'(ex_valid_ns), 64'd1);
        check("mult_allin_c3", 64'(ex_allin), 64'd1);
        commit();
        check("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);

        issue("divu", INSN_DIVU, 32'd100, 32'd7, 33);
        commit();
        check("divu_hilo", {hi, lo}, {32'd2, 32'd14});

        issue("div_neg", INSN_DIV, 32'hFFFF_FFF9, 32'd2, 33);
        commit();
        check("div_neg_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        issue("div_zero", INSN_DIV, 32'h0000_1234, 32'd0, 1);
        commit();
        check("div_zero_hilo", {hi, lo}, {32'h0000_1234, 32'hFFFF_FFFF});

        // DIVU aborted by flush at cycle 10
        op = INSN_DIVU; scr0_data = 32'd1000; scr1_data = 32'd3; ex_valid_in = 1'b1;
        for (int c = 0; c < 10; c++) tick();
        check("flush_busy_before", 64'(busy), 64'd1);
        flush = 1'b1;
        #1;
        check("flush_valid", 64'(ex_valid_ns), 64'd0);
        check("flush_allin", 64'(ex_allin), 64'd1);
        tick();
        flush = 1'b0; op = INSN_ADD; ex_valid_in = 1'b1; wb_allin = 1'b1;
        #1;
        check("flush_busy_after", 64'(busy), 64'd0);
        check("flush_hilo", {hi, lo}, {32'h0000_1234, 32'hFFFF_FFFF});
        check("add_valid_hi", 64'(ex_valid_ns), 64'd1);
        check("add_allin", 64'(ex_allin), 64'd1);
        ex_valid_in = 1'b0;
        #1;
        check("add_valid_lo", 64'(ex_valid_ns), 64'd0);

        // MULTU max*max with WB back-pressure in DONE
        wb_allin = 1'b0;
        issue("multu", INSN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("multu_hold_valid%0d", c), 64'(ex_valid_ns), 64'd1);
            check($sformatf("multu_hold_allin%0d", c), 64'(ex_allin), 64'd0);
            tick();
        end
        check("multu_hold_hilo", {hi, lo}, {32'h0000_1234, 32'hFFFF_FFFF});
        commit();
        check("multu_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

        // MTHI gated by wb_allin
        wb_allin = 1'b0; op = INSN_MTHI; scr0_data = 32'hA5A5_A5A5; ex_valid_in = 1'b1;
        tick();
        check("mthi_hold", 64'(hi), 64'hFFFF_FFFE);
        wb_allin = 1'b1;
        #1;
        check("mthi_allin", 64'(ex_allin), 64'd1);
        tick();
        check("mthi_write", 64'(hi), 64'hA5A5_A5A5);

        // MTLO suppressed by a simultaneous flush
        op = INSN_MTLO; scr0_data = 32'h5A5A_5A5A; flush = 1'b1;
        tick();
        flush = 1'b0; ex_valid_in = 1'b0; op = INSN_ADD;
        #1;
        check("mtlo_flushed", 64'(lo), 64'd1);

        // Asynchronous reset in the middle of a divide
        issue("pre_rst", INSN_DIVU, 32'd50, 32'd5, 33);
        commit();
        check("pre_rst_hilo", {hi, lo}, {32'd0, 32'd10});
        op = INSN_DIVU; scr0_data = 32'd50; scr1_data = 32'd5; ex_valid_in = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        check("mid_div_busy", 64'(busy), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_hilo", {hi, lo}, 64'd0);
        ex_valid_in = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_muldiv_ctrl
`default_nettype wire
